mux_bbm_ctrl: RTL and testbench
===============================

# mux_bbm_ctrl

Clocked, parametrised N-to-1 multiplexer with break-before-make channel switching, the next generation of the team's 2:1 static mux models. It owns a one-hot switch-enable bus (SEL_ON) that drives the per-channel switch controls of an RC mux array. It also provides a registered W-bit data path from the selected channel. Channel changes go through a REQ/ACK handshake with programmable dead time and settle time, so two channels are never connected at once.

## Interface
- N, 4, number of input channels (≥2)
- W, 8, data width per channel (≥1)
- DEAD, 2, break (all-off) cycles before a new channel is connected (≥1)
- SETTLE, 3, cycles the new channel is connected before ACK (≥1)
- Reset: one clock; reset is asynchronous and active-high.
- CLK  input  1  sole clock, rising edge
- RST  input  1  asynchronous, active-high reset
- REQ  input  1  channel-change request, sampled only in IDLE
- CH  input  $clog2(N)  requested channel index
- D  input  N*W  packed channel data, channel k at [k*W +: W]
- SEL_ON  output  N  one-hot switch enables (all-zero allowed)
- Y  output  W  registered output data
- VALID  output  1  Y reflects a connected, settled channel
- BUSY  output  1  switching in progress
- ACK  output  1  one-cycle pulse, request completed
- ERR  output  1  one-cycle pulse, request rejected (CH ≥ N)

## Operation
- Reset values: state IDLE; cur_ch=0; SEL_ON, Y, VALID, BUSY, ACK and ERR all 0. No channel is connected after reset.
- States: IDLE, BREAK, SETTLE.
- IDLE with REQ=1 and CH≥N: ERR=1 next cycle. No other state change.
- IDLE with REQ=1, CH==cur_ch and VALID=1 (fast path): ACK=1 next cycle. SEL_ON and VALID are unchanged and there is no break.
- IDLE with REQ=1 and any other valid CH:
  - Capture CH into cur_ch and go to BREAK.
  - SEL_ON=0, VALID=0, BUSY=1.
- BREAK: held for DEAD cycles, then go to SETTLE with SEL_ON=one-hot(cur_ch).
- SETTLE: held for SETTLE cycles, then go to IDLE with ACK=1, VALID=1, BUSY=0.
- SEL_ON never has more than one bit set in any cycle.
- Y path:
  - While VALID=1, Y <= D[cur_ch] every cycle.
  - While VALID=0, Y follows the configuration rule below.
- REQ outside IDLE is ignored and not queued. A requester keeps REQ high until ACK or ERR.
- REQ high in the ACK cycle is a new request; the block is already in IDLE.
- RST mid-operation forces all reset values immediately. After RST is released, the first REQ behaves as the first request after reset.
- Elaboration: $error if N<2, W<1, DEAD<1 or SETTLE<1.

## Timing
- Cycle 0 = REQ sampled in IDLE.
- Full switch:
  - Cycles 1..DEAD: BREAK.
  - Cycles DEAD+1..DEAD+SETTLE: SETTLE, SEL_ON one-hot.
  - Cycle DEAD+SETTLE+1: ACK=1, VALID=1.
  - Latency is DEAD+SETTLE+1 cycles.
- Fast path and ERR: 1 cycle.
- Y latency from D: 1 cycle, registered.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: MUX_BBM_HOLD_EN.
- Defined: Y holds its last value while VALID=0 (BREAK and SETTLE); Y is still 0 after reset.
- Undefined: Y is forced to 0 whenever VALID=0.

## Structure
- Package mux_pkg holds:
  - enum mux_state_t {IDLE, BREAK, SETTLE}.
  - Function onehot(idx, N).
  - Localparam for the counter width, $clog2(max(DEAD, SETTLE)+1).
- One sub-module, mux_dwell_cnt:
  - Loadable down-counter with a done flag.
  - Loaded with DEAD on entry to BREAK and with SETTLE on entry to SETTLE.

## Test plan
All scenarios use N=4, W=8, DEAD=2, SETTLE=3 unless noted.
- Reset, then REQ with CH=2 and D[2]=8'hA5 → SEL_ON=0000 in cycles 1–2; SEL_ON=0100 from cycle 3; ACK and VALID at cycle 6; Y=8'hA5 at cycle 6.
- Switch 2→1 → SEL_ON goes 0100 → 0000 for 2 cycles → 0010. Assert one-hot-or-zero on every cycle.
- REQ with CH=1 while connected to 1 and VALID=1 → ACK at cycle 1; SEL_ON stays 0010; VALID never drops.
- Variant N=3: REQ with CH=3 → ERR pulse at cycle 1; no ACK; SEL_ON, VALID and Y unchanged.
- RST asserted in the 2nd SETTLE cycle → all outputs 0 immediately. After release, REQ with CH=0 completes in 6 cycles.
- REQ toggling during BUSY is ignored. With MUX_BBM_HOLD_EN defined, Y keeps its old value in cycles 1–5; without it, Y=0 in cycles 1–5.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the break-before-make channel mux (mux_bbm_ctrl).
//   mux_state_t : controller states IDLE / BREAK / SETTLE
//   cnt_width() : dwell counter width needed to hold max(dead, settle)
//   CNT_W       : counter width for the default timing (DEAD=2, SETTLE=3)
//   onehot()    : index -> one-hot vector (MAX_N bits, zero if idx >= n)
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREAK  = 2'd1,
        SETTLE = 2'd2
    } mux_state_t;

    // Widest channel count onehot() can encode.
    localparam int MAX_N = 64;

    localparam int DEF_DEAD   = 2;
    localparam int DEF_SETTLE = 3;

    // The counter is loaded with DEAD or SETTLE directly, so it must be able
    // to represent the larger of the two.
    function automatic int cnt_width(input int dead, input int settle);
        int m;
        m = (dead > settle) ? dead : settle;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_DEAD, DEF_SETTLE);

    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n) begin
            v = {{(MAX_N-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/mux_dwell_cnt.sv
// -----------------------------------------------------------------------------
// mux_dwell_cnt
// Loadable down-counter that times how long the controller dwells in BREAK
// and SETTLE.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : dwell length in cycles (>= 1)
//   done      : high during the last cycle of the dwell
// After a load of V the counter reads V in the first dwell cycle and counts
// down by one per cycle, so done is high in the V-th cycle. It parks at 0.
// -----------------------------------------------------------------------------
module mux_dwell_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/mux_bbm_ctrl.sv
// -----------------------------------------------------------------------------
// mux_bbm_ctrl
// N-to-1 clocked mux with break-before-make switching of a one-hot switch
// enable bus and a registered W-bit data path from the connected channel.
//
// Ports
//   CLK, RST  : rising-edge clock, asynchronous active-high reset
//   REQ, CH   : channel-change request and requested channel index
//   D         : packed channel data, channel k at D[k*W +: W]
//   SEL_ON    : one-hot (or all-zero) switch enables
//   Y         : registered data of the connected channel
//   VALID     : Y comes from a connected and settled channel
//   BUSY      : a switch is in progress
//   ACK / ERR : one-cycle completion / rejection pulses
//   DBG_STATE : current controller state, for observation only
//
// Handshake: REQ is sampled only in IDLE. The requester holds REQ (and CH)
// until it sees ACK or ERR; REQ seen outside IDLE is ignored, never queued.
// REQ still high in the ACK/ERR cycle counts as a new request.
//
// Build option: define MUX_BBM_HOLD_EN to make Y hold its last value while
// VALID=0; by default Y is driven to 0 whenever VALID=0.
// -----------------------------------------------------------------------------
module mux_bbm_ctrl #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int DEAD   = 2,
    parameter int SETTLE = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ,
    input  logic [$clog2(N)-1:0]   CH,
    input  logic [N*W-1:0]         D,
    output logic [N-1:0]           SEL_ON,
    output logic [W-1:0]           Y,
    output logic                   VALID,
    output logic                   BUSY,
    output logic                   ACK,
    output logic                   ERR,
    output mux_pkg::mux_state_t    DBG_STATE
);
    // The local parameter SETTLE shadows the package state literal of the
    // same name, so that state is always written as mux_pkg::SETTLE here.
    import mux_pkg::*;

    localparam int CHW = $clog2(N);
    localparam int CW  = cnt_width(DEAD, SETTLE);
    localparam logic [CHW:0] N_L = (CHW+1)'(N);

    if (N < 2 || W < 1 || DEAD < 1 || SETTLE < 1) begin : g_bad_param
        $error("mux_bbm_ctrl: need N>=2, W>=1, DEAD>=1, SETTLE>=1");
    end

    // Channel data as an array so the selected word is a plain index.
    logic [W-1:0] d_arr [N];
    for (genvar k = 0; k < N; k++) begin : g_split
        assign d_arr[k] = D[k*W +: W];
    end

    mux_state_t     state_q, state_d;
    logic [CHW-1:0] cur_ch_q, cur_ch_d;
    logic [N-1:0]   sel_q, sel_d;
    logic [W-1:0]   y_q, y_d, y_idle;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           cnt_load;
    logic [CW-1:0]  cnt_val;
    logic           cnt_done;

    mux_dwell_cnt #(.CW(CW)) u_dwell (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;

        case (state_q)
            IDLE: begin
                if (REQ) begin
                    if ({1'b0, CH} >= N_L) begin
                        err_d = 1'b1;
                    end else if (CH == cur_ch_q && valid_q) begin
                        // Already connected and settled: acknowledge without
                        // touching the switches.
                        ack_d = 1'b1;
                    end else begin
                        // Open every switch first; the new channel is only
                        // closed after the dead time has elapsed.
                        cur_ch_d = CH;
                        sel_d    = '0;
                        valid_d  = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = BREAK;
                        cnt_load = 1'b1;
                        cnt_val  = CW'(DEAD);
                    end
                end
            end
            BREAK: begin
                if (cnt_done) begin
                    sel_d    = N'(onehot(int'(cur_ch_q), N));
                    state_d  = mux_pkg::SETTLE;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(SETTLE);
                end
            end
            mux_pkg::SETTLE: begin
                if (cnt_done) begin
                    ack_d   = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

`ifdef MUX_BBM_HOLD_EN
        y_idle = y_q;
`else
        y_idle = '0;
`endif
        // Keyed on the next VALID so Y carries fresh data in the ACK cycle.
        y_d = valid_d ? d_arr[cur_ch_q] : y_idle;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
            sel_q    <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            sel_q    <= sel_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign SEL_ON    = sel_q;
    assign Y         = y_q;
    assign VALID     = valid_q;
    assign BUSY      = busy_q;
    assign ACK       = ack_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mux_bbm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_bbm_ctrl
// Directed bench for mux_bbm_ctrl: an N=4 instance for switching, fast path,
// Y tracking and mid-operation reset, plus an N=3 instance for rejected
// channel indices. Expected ACK/ERR responses are queued by the stimulus and
// popped by per-instance monitors; per-cycle expectations are checked inline.
// -----------------------------------------------------------------------------
module tb_mux_bbm_ctrl;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int DEAD   = 2;
  localparam int SETTLE = 3;
  localparam int LAT    = DEAD + SETTLE + 1;
  localparam int RW     = 1 + 4 + 1 + W;  // {err, sel[3:0], valid, y}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- N=4 instance ----------------
  logic                req = 1'b0;
  logic [1:0]          ch = '0;
  logic [N*W-1:0]      d;
  logic [N-1:0]        sel_on;
  logic [W-1:0]        y;
  logic                valid, busy, ack, err;
  mux_pkg::mux_state_t st;

  mux_bbm_ctrl #(.N(N), .W(W), .DEAD(DEAD), .SETTLE(SETTLE)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .CH(ch), .D(d),
    .SEL_ON(sel_on), .Y(y), .VALID(valid), .BUSY(busy),
    .ACK(ack), .ERR(err), .DBG_STATE(st)
  );

  // ---------------- N=3 instance ----------------
  logic                req3 = 1'b0;
  logic [1:0]          ch3 = '0;
  logic [3*W-1:0]      d3;
  logic [2:0]          sel3;
  logic [W-1:0]        y3;
  logic                valid3, busy3, ack3, err3;
  mux_pkg::mux_state_t st3;

  mux_bbm_ctrl #(.N(3), .W(W), .DEAD(DEAD), .SETTLE(SETTLE)) dut3 (
    .CLK(clk), .RST(rst), .REQ(req3), .CH(ch3), .D(d3),
    .SEL_ON(sel3), .Y(y3), .VALID(valid3), .BUSY(busy3),
    .ACK(ack3), .ERR(err3), .DBG_STATE(st3)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp3_q[$];
  logic [RW-1:0] e4, e3;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dch(input int k);
    return d[k*W +: W];
  endfunction

  // Monitors: pop one expected record per ACK/ERR pulse.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sel_onehot0", 32'($onehot0(sel_on)), 32'd1);
      if (ack || err) begin
        chk("ack_err_excl", 32'(ack & err), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'({ack, err}), 32'd0);
        end else begin
          e4 = exp_q.pop_front();
          chk("resp4", 32'({err, sel_on, valid, y}), 32'(e4));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("sel3_onehot0", 32'($onehot0(sel3)), 32'd1);
      if (ack3 || err3) begin
        if (exp3_q.size() == 0) begin
          chk("unexpected_resp3", 32'({ack3, err3}), 32'd0);
        end else begin
          e3 = exp3_q.pop_front();
          chk("resp3", 32'({err3, 1'b0, sel3, valid3, y3}), 32'(e3));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Full switch to channel c. y_hold is the Y value expected to be held
  // while VALID=0 when MUX_BBM_HOLD_EN is defined.
  task automatic do_switch(input logic [1:0] c, input bit toggle, input logic [W-1:0] y_hold);
    logic [3:0] oh;
    oh = 4'b0001 << c;
    @(negedge clk); #1;
    req = 1'b1;
    ch  = c;
    exp_q.push_back({1'b0, oh, 1'b1, dch(int'(c))});
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        chk("busy_sw", 32'(busy), 32'd1);
        chk("valid_sw", 32'(valid), 32'd0);
        chk("ack_sw", 32'(ack), 32'd0);
`ifdef MUX_BBM_HOLD_EN
        chk("y_hold_sw", 32'(y), 32'(y_hold));
`else
        chk("y_zero_sw", 32'(y), 32'd0);
`endif
        if (k == 1) chk("state_break", 32'(st), 32'(mux_pkg::BREAK));
        if (k <= DEAD) chk("sel_break", 32'(sel_on), 32'd0);
        else           chk("sel_settle", 32'(sel_on), 32'(oh));
        if (toggle) begin
          req = k[0];
          ch  = 2'(k);
        end
      end else begin
        chk("busy_done", 32'(busy), 32'd0);
        chk("valid_done", 32'(valid), 32'd1);
        req = 1'b0;
      end
    end
    #1 chk("resp4_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_fast(input logic [1:0] c);
    logic [3:0] oh;
    oh = 4'b0001 << c;
    @(negedge clk); #1;
    chk("fast_valid_before", 32'(valid), 32'd1);
    req = 1'b1;
    ch  = c;
    exp_q.push_back({1'b0, oh, 1'b1, dch(int'(c))});
    @(negedge clk);
    chk("fast_busy", 32'(busy), 32'd0);
    req = 1'b0;
    #1 chk("resp4_seen_fast", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("fast_valid_after", 32'(valid), 32'd1);
    chk("fast_sel_after", 32'(sel_on), 32'(oh));
    chk("fast_ack_pulse", 32'(ack), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   32'(sel_on), 32'd0);
    chk({tag, "_y"},     32'(y),      32'd0);
    chk({tag, "_valid"}, 32'(valid),  32'd0);
    chk({tag, "_busy"},  32'(busy),   32'd0);
    chk({tag, "_ack"},   32'(ack),    32'd0);
    chk({tag, "_err"},   32'(err),    32'd0);
    chk({tag, "_state"}, 32'(st),     32'(mux_pkg::IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    d  = {8'h3C, 8'hA5, 8'h5A, 8'hC3};   // ch3..ch0
    d3 = {8'h99, 8'h66, 8'h11};          // ch2..ch0
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    chk("rst3_sel", 32'(sel3), 32'd0);
    chk("rst3_y", 32'(y3), 32'd0);
    chk("rst3_flags", 32'({valid3, busy3, ack3, err3}), 32'd0);
    chk("rst3_state", 32'(st3), 32'(mux_pkg::IDLE));
    #1 rst = 1'b0;

    // N=3: out-of-range request from reset state.
    @(negedge clk); #1;
    req3 = 1'b1; ch3 = 2'd3;
    exp3_q.push_back({1'b1, 4'b0000, 1'b0, 8'h00});
    @(negedge clk);
    chk("err3_no_ack", 32'(ack3), 32'd0);
    chk("err3_no_busy", 32'(busy3), 32'd0);
    req3 = 1'b0;
    #1 chk("resp3_seen_a", 32'(exp3_q.size()), 32'd0);
    @(negedge clk);
    chk("err3_pulse", 32'(err3), 32'd0);

    // N=3: connect channel 2, then reject again while connected.
    #1 req3 = 1'b1; ch3 = 2'd2;
    exp3_q.push_back({1'b0, 4'b0100, 1'b1, 8'h99});
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) chk("ack3_early", 32'(ack3), 32'd0);
    end
    req3 = 1'b0;
    #1 chk("resp3_seen_b", 32'(exp3_q.size()), 32'd0);
    @(negedge clk); #1;
    req3 = 1'b1; ch3 = 2'd3;
    exp3_q.push_back({1'b1, 4'b0100, 1'b1, 8'h99});
    @(negedge clk);
    req3 = 1'b0;
    #1 chk("resp3_seen_c", 32'(exp3_q.size()), 32'd0);

    // N=4: first switch after reset to channel 2.
    do_switch(2'd2, 1'b0, 8'h00);

    // Y follows D of the connected channel with one cycle of latency.
    #1 d[2*W +: W] = 8'h7E;
    @(negedge clk);
    chk("y_track", 32'(y), 32'h7E);

    // Switch 2 -> 1 with REQ/CH toggling while busy.
    do_switch(2'd1, 1'b1, 8'h7E);

    // Fast path: already on channel 1.
    do_fast(2'd1);

    // Reset in the second SETTLE cycle of a switch to channel 3.
    @(negedge clk); #1;
    req = 1'b1; ch = 2'd3;
    repeat (DEAD + 2) @(negedge clk);
    chk("pre_rst_sel", 32'(sel_on), 32'b1000);
    #1 rst = 1'b1; req = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;

    // First request after reset: channel 0 takes the full switch.
    do_switch(2'd0, 1'b0, 8'h00);

    repeat (2) @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size() + exp3_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
